// File: rtl/transfer_executor.sv
// Register-transfer datapath for a small control unit: executes one transfer code
// per cycle and runs single outstanding memory reads/writes through a two-state FSM.
module transfer_executor #(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter logic [7:0] SP_RESET = 8'hFF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_transfer_cmd,
  input  logic       i_inc_pc,
  input  logic [1:0] i_inc_dec_sp,
  input  logic       i_ap_sel,
  input  logic       i_reset_ir,
  input  logic [7:0] i_alu_result,
  input  logic [7:0] i_in_port,
  input  logic       i_mem_ack,
  input  logic [7:0] i_mem_rdata,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic [7:0] o_mem_addr,
  output logic [7:0] o_mem_wdata,
  output logic       o_busy,
  output logic [7:0] o_opcode,
  output logic [7:0] o_a,
  output logic [7:0] o_ap,
  output logic [7:0] o_out_port,
  output logic       o_out_valid
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0] r_state;
  logic       r_mem_we;
  logic       r_out_valid;
  logic [7:0] r_pc, r_ma, r_md, r_ir, r_a, r_ap, r_sp, r_out;
  logic       w_idle;

  assign w_idle = (r_state == ST_IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_mem_we    <= 1'b0;
      r_out_valid <= 1'b0;
      r_pc        <= PC_RESET;
      r_sp        <= SP_RESET;
      r_ma        <= '0;
      r_md        <= '0;
      r_ir        <= '0;
      r_a         <= '0;
      r_ap        <= '0;
      r_out       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (!w_idle) begin
        if (i_mem_ack) begin
          r_state  <= ST_IDLE;
          r_mem_we <= 1'b0;
          if (!r_mem_we) r_md <= i_mem_rdata;
        end
      end else begin
        case (i_transfer_cmd)
          4'h1: r_ma <= r_pc;
          4'h2: begin r_state <= ST_WAIT; r_mem_we <= 1'b0; end
          4'h4: r_ma <= r_md;
          4'h5: if (i_ap_sel) r_ap <= r_md; else r_a <= r_md;
          4'h6: r_ma <= r_ap;
          4'h7: r_ma <= r_sp;
          4'h8: r_md <= i_ap_sel ? r_ap : r_a;
          4'h9: begin r_state <= ST_WAIT; r_mem_we <= 1'b1; end
          4'hA: if (i_ap_sel) r_ap <= i_alu_result; else r_a <= i_alu_result;
          4'hC: r_a <= i_in_port;
          4'hD: begin r_out <= r_a; r_out_valid <= 1'b1; end
          4'hF: r_md <= r_pc;
          default: ;
        endcase

        // Explicit loads into PC/IR outrank the increment / clear side requests.
        if (i_transfer_cmd == 4'hB)      r_pc <= r_md;
        else if (i_transfer_cmd == 4'hE) r_pc <= r_ap;
        else if (i_inc_pc)               r_pc <= r_pc + 8'd1;

        if (i_transfer_cmd == 4'h3) r_ir <= r_md;
        else if (i_reset_ir)        r_ir <= '0;

        case (i_inc_dec_sp)
          2'b01:   r_sp <= r_sp + 8'd1;
          2'b10:   r_sp <= r_sp - 8'd1;
          default: ;
        endcase
      end
    end
  end

  assign o_mem_req   = (r_state == ST_WAIT);
  assign o_busy      = (r_state == ST_WAIT);
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_ma;
  assign o_mem_wdata = r_md;
  assign o_opcode    = r_ir;
  assign o_a         = r_a;
  assign o_ap        = r_ap;
  assign o_out_port  = r_out;
  assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_transfer_executor.sv
// Bench for transfer_executor: a vector table of single-cycle transfers plus
// hand sequences for fetch, stack write, busy blocking and reset during a read.
module tb_transfer_executor;

  logic       i_clk, i_rst;
  logic [3:0] i_transfer_cmd;
  logic       i_inc_pc, i_ap_sel, i_reset_ir, i_mem_ack;
  logic [1:0] i_inc_dec_sp;
  logic [7:0] i_alu_result, i_in_port, i_mem_rdata;
  logic       o_mem_req, o_mem_we, o_busy, o_out_valid;
  logic [7:0] o_mem_addr, o_mem_wdata, o_opcode, o_a, o_ap, o_out_port;

  transfer_executor #(.PC_RESET(8'h00), .SP_RESET(8'hFF)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_transfer_cmd(i_transfer_cmd),
    .i_inc_pc(i_inc_pc), .i_inc_dec_sp(i_inc_dec_sp), .i_ap_sel(i_ap_sel),
    .i_reset_ir(i_reset_ir), .i_alu_result(i_alu_result), .i_in_port(i_in_port),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_busy(o_busy), .o_opcode(o_opcode),
    .o_a(o_a), .o_ap(o_ap), .o_out_port(o_out_port), .o_out_valid(o_out_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  localparam int NONE = 0, ADDR = 1, WDATA = 2, OPC = 3, AREG = 4, APREG = 5,
                 OUTP = 6, OUTV = 7, BUSY = 8, REQ = 9, WE = 10;

  typedef struct {
    logic [3:0] cmd; logic inc_pc; logic [1:0] sp; logic ap_sel; logic rst_ir;
    logic [7:0] alu; logic [7:0] inp;
    int s1; logic [7:0] e1; int s2; logic [7:0] e2;
  } vec_t;

  typedef struct { int sel; logic [7:0] val; string name; } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  vec_t tbl[28];

  function automatic vec_t mk(logic [3:0] cmd, logic inc, logic [1:0] sp, logic aps,
                              logic rir, logic [7:0] alu, logic [7:0] inp,
                              int s1, logic [7:0] e1, int s2, logic [7:0] e2);
    vec_t v;
    v.cmd = cmd; v.inc_pc = inc; v.sp = sp; v.ap_sel = aps; v.rst_ir = rir;
    v.alu = alu; v.inp = inp; v.s1 = s1; v.e1 = e1; v.s2 = s2; v.e2 = e2;
    return v;
  endfunction

  function automatic logic [7:0] obs(int s);
    case (s)
      ADDR:  return o_mem_addr;
      WDATA: return o_mem_wdata;
      OPC:   return o_opcode;
      AREG:  return o_a;
      APREG: return o_ap;
      OUTP:  return o_out_port;
      OUTV:  return {7'd0, o_out_valid};
      BUSY:  return {7'd0, o_busy};
      REQ:   return {7'd0, o_mem_req};
      WE:    return {7'd0, o_mem_we};
      default: return 8'hxx;
    endcase
  endfunction

  task automatic expect_v(int sel, logic [7:0] val, string name);
    exp_t e;
    e.sel = sel; e.val = val; e.name = name;
    if (sel != NONE) sbq.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [7:0] a;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = obs(e.sel);
      total++;
      if (a !== e.val) begin
        bad++;
        $display("FAIL %s: got %02h want %02h", e.name, a, e.val);
      end
    end
  endtask

  task automatic drive(logic [3:0] cmd, logic inc, logic [1:0] sp, logic aps, logic rir,
                       logic [7:0] alu, logic [7:0] inp);
    i_transfer_cmd = cmd; i_inc_pc = inc; i_inc_dec_sp = sp; i_ap_sel = aps;
    i_reset_ir = rir; i_alu_result = alu; i_in_port = inp;
    i_mem_ack = 1'b0; i_mem_rdata = 8'h00;
  endtask

  // One clock: let the edge happen, then compare everything queued for it.
  task automatic step();
    @(posedge i_clk);
    #2;
    check_all();
  endtask

  task automatic cmd1(logic [3:0] cmd, logic aps, logic [7:0] inp);
    drive(cmd, 1'b0, 2'b00, aps, 1'b0, 8'h00, inp);
    step();
  endtask

  // PC <- v via A -> MD -> PC
  task automatic load_pc(logic [7:0] v);
    cmd1(4'hC, 1'b0, v);
    cmd1(4'h8, 1'b0, 8'h00);
    cmd1(4'hB, 1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    i_rst = 1'b1;
    drive(4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
    #12;
    expect_v(BUSY, 8'h00, "rst_busy");   expect_v(REQ, 8'h00, "rst_req");
    expect_v(WE, 8'h00, "rst_we");       expect_v(OPC, 8'h00, "rst_ir");
    expect_v(AREG, 8'h00, "rst_a");      expect_v(APREG, 8'h00, "rst_ap");
    expect_v(OUTV, 8'h00, "rst_outv");   expect_v(OUTP, 8'h00, "rst_out");
    expect_v(ADDR, 8'h00, "rst_ma");     expect_v(WDATA, 8'h00, "rst_md");
    check_all();
    i_rst = 1'b0;

    tbl[0]  = mk(4'h1, 0, 2'b00, 0, 0, 8'h00, 8'h00, ADDR,  8'h00, NONE, 8'h00);
    tbl[1]  = mk(4'h7, 0, 2'b00, 0, 0, 8'h00, 8'h00, ADDR,  8'hFF, NONE, 8'h00);
    tbl[2]  = mk(4'hC, 0, 2'b00, 0, 0, 8'h00, 8'h10, AREG,  8'h10, NONE, 8'h00);
    tbl[3]  = mk(4'h8, 0, 2'b00, 0, 0, 8'h00, 8'h00, WDATA, 8'h10, NONE, 8'h00);
    tbl[4]  = mk(4'hB, 1, 2'b00, 0, 0, 8'h00, 8'h00, BUSY,  8'h00, NONE, 8'h00);
    tbl[5]  = mk(4'h1, 0, 2'b00, 0, 0, 8'h00, 8'h00, ADDR,  8'h10, NONE, 8'h00);
    tbl[6]  = mk(4'hA, 0, 2'b00, 1, 0, 8'h80, 8'h00, APREG, 8'h80, AREG, 8'h10);
    tbl[7]  = mk(4'hA, 0, 2'b00, 0, 0, 8'hC3, 8'h00, AREG,  8'hC3, APREG, 8'h80);
    tbl[8]  = mk(4'h6, 0, 2'b00, 0, 0, 8'h00, 8'h00, ADDR,  8'h80, NONE, 8'h00);
    tbl[9]  = mk(4'hE, 1, 2'b00, 0, 0, 8'h00, 8'h00, NONE,  8'h00, NONE, 8'h00);
    tbl[10] = mk(4'hF, 0, 2'b00, 0, 0, 8'h00, 8'h00, WDATA, 8'h80, NONE, 8'h00);
    tbl[11] = mk(4'h3, 0, 2'b00, 0, 0, 8'h00, 8'h00, OPC,   8'h80, NONE, 8'h00);
    tbl[12] = mk(4'h0, 0, 2'b00, 0, 1, 8'h00, 8'h00, OPC,   8'h00, NONE, 8'h00);
    tbl[13] = mk(4'h3, 0, 2'b00, 0, 1, 8'h00, 8'h00, OPC,   8'h80, NONE, 8'h00);
    tbl[14] = mk(4'h5, 0, 2'b00, 0, 0, 8'h00, 8'h00, AREG,  8'h80, NONE, 8'h00);
    tbl[15] = mk(4'h7, 0, 2'b01, 0, 0, 8'h00, 8'h00, ADDR,  8'hFF, NONE, 8'h00);
    tbl[16] = mk(4'h7, 0, 2'b00, 0, 0, 8'h00, 8'h00, ADDR,  8'h00, NONE, 8'h00);
    tbl[17] = mk(4'h0, 0, 2'b10, 0, 0, 8'h00, 8'h00, BUSY,  8'h00, NONE, 8'h00);
    tbl[18] = mk(4'h7, 0, 2'b11, 0, 0, 8'h00, 8'h00, ADDR,  8'hFF, NONE, 8'h00);
    tbl[19] = mk(4'h7, 0, 2'b00, 0, 0, 8'h00, 8'h00, ADDR,  8'hFF, NONE, 8'h00);
    tbl[20] = mk(4'hC, 0, 2'b00, 0, 0, 8'h00, 8'hFF, AREG,  8'hFF, NONE, 8'h00);
    tbl[21] = mk(4'h8, 0, 2'b00, 0, 0, 8'h00, 8'h00, WDATA, 8'hFF, NONE, 8'h00);
    tbl[22] = mk(4'hB, 0, 2'b00, 0, 0, 8'h00, 8'h00, OPC,   8'h80, NONE, 8'h00);
    tbl[23] = mk(4'h1, 1, 2'b00, 0, 0, 8'h00, 8'h00, ADDR,  8'hFF, NONE, 8'h00);
    tbl[24] = mk(4'h1, 0, 2'b00, 0, 0, 8'h00, 8'h00, ADDR,  8'h00, NONE, 8'h00);
    tbl[25] = mk(4'hC, 0, 2'b00, 0, 0, 8'h00, 8'h5A, AREG,  8'h5A, NONE, 8'h00);
    tbl[26] = mk(4'hD, 0, 2'b00, 0, 0, 8'h00, 8'h00, OUTP,  8'h5A, OUTV, 8'h01);
    tbl[27] = mk(4'h0, 0, 2'b00, 0, 0, 8'h00, 8'h00, OUTV,  8'h00, OUTP, 8'h5A);

    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].cmd, tbl[i].inc_pc, tbl[i].sp, tbl[i].ap_sel, tbl[i].rst_ir,
            tbl[i].alu, tbl[i].inp);
      expect_v(tbl[i].s1, tbl[i].e1, $sformatf("vec%0d_a", i));
      expect_v(tbl[i].s2, tbl[i].e2, $sformatf("vec%0d_b", i));
      step();
    end

    // Fetch with blocked commands during WAIT
    load_pc(8'h10);
    drive(4'h1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
    expect_v(ADDR, 8'h10, "fetch_ma");
    step();
    drive(4'h2, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
    expect_v(BUSY, 8'h01, "fetch_busy"); expect_v(REQ, 8'h01, "fetch_req");
    expect_v(WE, 8'h00, "fetch_we");
    step();
    cnt = 1;
    for (int n = 0; n < 20; n++) begin
      drive(4'h1, 1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 8'h00);
      i_mem_ack = (cnt == 3);
      i_mem_rdata = 8'h3B;
      expect_v(ADDR, 8'h10, "fetch_hold_ma");
      step();
      if (o_busy) cnt++;
      else break;
    end
    total++;
    if (cnt != 3) begin
      bad++;
      $display("FAIL fetch_busy_cycles: got %0d want 3", cnt);
    end
    drive(4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
    expect_v(REQ, 8'h00, "fetch_req_drop"); expect_v(WDATA, 8'h3B, "fetch_md");
    expect_v(OPC, 8'h80, "blocked_ir");
    step();
    drive(4'h3, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
    expect_v(OPC, 8'h3B, "fetch_ir");
    step();
    drive(4'h1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
    expect_v(ADDR, 8'h11, "fetch_pc");
    step();
    drive(4'h7, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
    expect_v(ADDR, 8'hFF, "blocked_sp");
    step();
    drive(4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
    i_mem_ack = 1'b1; i_mem_rdata = 8'h77;
    step();
    drive(4'h4, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
    expect_v(ADDR, 8'h3B, "idle_ack_md");
    step();

    // Stack write after a clean reset
    @(posedge i_clk); #2;
    i_rst = 1'b1; #2; i_rst = 1'b0;
    cmd1(4'h0, 1'b0, 8'h00);
    drive(4'h0, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 8'h00); step();
    drive(4'h0, 1'b0, 2'b10, 1'b0, 1'b0, 8'h00, 8'h00); step();
    drive(4'h7, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
    expect_v(ADDR, 8'hFF, "stack_ma");
    step();
    drive(4'hA, 1'b0, 2'b00, 1'b1, 1'b0, 8'h42, 8'h00); step();
    drive(4'h8, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00);
    expect_v(WDATA, 8'h42, "stack_md");
    step();
    drive(4'h9, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
    expect_v(REQ, 8'h01, "wr_req"); expect_v(WE, 8'h01, "wr_we");
    expect_v(ADDR, 8'hFF, "wr_addr"); expect_v(WDATA, 8'h42, "wr_data");
    step();
    drive(4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
    i_mem_ack = 1'b1; i_mem_rdata = 8'hEE;
    expect_v(BUSY, 8'h00, "wr_done"); expect_v(WDATA, 8'h42, "wr_md_kept");
    step();

    // Reset while a read is outstanding
    drive(4'h0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00); step();
    drive(4'h2, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
    expect_v(REQ, 8'h01, "rr_req");
    step();
    drive(4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
    i_rst = 1'b1;
    #1;
    expect_v(REQ, 8'h00, "rr_req_async"); expect_v(BUSY, 8'h00, "rr_busy_async");
    check_all();
    #1; i_rst = 1'b0;
    i_mem_ack = 1'b1; i_mem_rdata = 8'h99;
    expect_v(WDATA, 8'h00, "rr_late_ack");
    step();
    drive(4'h1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
    expect_v(ADDR, 8'h00, "rr_pc");
    step();
    drive(4'h7, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
    expect_v(ADDR, 8'hFF, "rr_sp");
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/transfer_executor.md
TRANSFER_EXECUTOR -- requirements
Module: transfer_executor

Interface
REQ-001 Parameter PC_RESET, 8'h00, PC value loaded on reset.
REQ-002 Parameter SP_RESET, 8'hFF, SP value loaded on reset.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst  input  1  asynchronous, active-high reset.
REQ-005 i_transfer_cmd  input  4  transfer code 0..F, per the control-unit encoding.
REQ-006 i_inc_pc  input  1  PC increment request.
REQ-007 i_inc_dec_sp  input  2  SP control: 01 = increment, 10 = decrement, 00/11 = hold.
REQ-008 i_ap_sel  input  1  selects AP (1) or A (0) for the A/AP codes 5, 8 and A.
REQ-009 i_reset_ir  input  1  clears IR.
REQ-010 i_alu_result  input  8  ALU result R.
REQ-011 i_in_port  input  8  input port data.
REQ-012 i_mem_ack  input  1  memory completion strobe.
REQ-013 i_mem_rdata  input  8  memory read data, valid with i_mem_ack.
REQ-014 o_mem_req  output  1  memory request, held until ack.
REQ-015 o_mem_we  output  1  1 = write, 0 = read; valid while o_mem_req is high.
REQ-016 o_mem_addr  output  8  memory address, equal to MA.
REQ-017 o_mem_wdata  output  8  write data, equal to MD.
REQ-018 o_busy  output  1  memory transaction in progress; commands are ignored while high.
REQ-019 o_opcode  output  8  IR contents.
REQ-020 o_a, o_ap  output  8 each  A and AP register contents.
REQ-021 o_out_port  output  8  output register; o_out_valid  output  1  one-cycle strobe on each update.

Function
REQ-022 Registers: PC, MA, MD, IR, A, AP, SP (8 bits each) and OUT.
REQ-023 Memory FSM states: IDLE and WAIT. A command is accepted only in IDLE. o_busy SHALL be 1 exactly when the FSM is in WAIT.
REQ-024 Codes accepted in IDLE update registers on the same edge:
- 1: MA<-PC
- 3: IR<-MD
- 4: MA<-MD
- 5: A/AP<-MD
- 6: MA<-AP
- 7: MA<-SP
- 8: MD<-A/AP
- A: A/AP<-i_alu_result
- B: PC<-MD
- C: A<-i_in_port
- D: OUT<-A, o_out_valid=1 next cycle only
- E: PC<-AP
- F: MD<-PC
- 0: no transfer
REQ-025 Code 2 in IDLE: move to WAIT with o_mem_req=1, o_mem_we=0.
REQ-026 Code 9 in IDLE: move to WAIT with o_mem_req=1, o_mem_we=1.
REQ-027 In WAIT, MA, MD, o_mem_req and o_mem_we SHALL be held stable.
REQ-028 When i_mem_ack=1 in WAIT: a read sets MD<-i_mem_rdata; the FSM returns to IDLE; o_mem_req drops the next cycle. Minimum transaction time is 1 busy cycle.
REQ-029 i_mem_ack outside WAIT SHALL be ignored.
REQ-030 i_inc_pc and i_inc_dec_sp are applied only when the command is accepted (IDLE), concurrently with that command.
REQ-031 Codes B or E take priority over i_inc_pc in the same cycle.
REQ-032 PC and SP arithmetic is modulo 256: PC FF->00; SP FF+1->00; SP 00-1->FF.
REQ-033 Code 7 with a same-cycle SP change: MA receives the pre-update SP.
REQ-034 Code 3 takes priority over i_reset_ir; i_reset_ir alone sets IR<-00.
REQ-035 Commands, i_inc_pc, i_inc_dec_sp and i_reset_ir presented while o_busy=1 SHALL have no effect.
REQ-036 No combinational path from any input to o_mem_req, o_mem_we or o_busy.

Reset
REQ-037 On i_rst=1, asynchronously:
- PC=PC_RESET, SP=SP_RESET
- MA, MD, IR, A, AP, OUT = 00
- FSM=IDLE
- o_mem_req=0, o_mem_we=0, o_busy=0, o_out_valid=0
REQ-038 Reset asserted in WAIT SHALL drop o_mem_req immediately and abandon the transaction. A late i_mem_ack after reset is ignored.
REQ-039 After i_rst deasserts, the first rising edge accepts commands.

Verification
REQ-040 Fetch: PC=10, cmd 1; then cmd 2 with inc_pc, ack after 3 cycles with rdata=3B; then cmd 3 -> o_busy high for exactly 3 cycles, PC=11, MD=3B, o_opcode=3B.
REQ-041 Stack: SP=00, inc_dec_sp=10 -> SP=FF; cmd 7 -> MA=FF; AP=42, ap_sel=1, cmd 8 -> MD=42; cmd 9 -> write req with addr FF, wdata 42, we=1.
REQ-042 Priority: MD=80, cmd B with inc_pc=1 -> PC=80. PC=FF, inc_pc alone -> PC=00.
REQ-043 Busy blocking: during WAIT, apply cmd 1, inc_pc and reset_ir -> PC, MA and IR unchanged. Ack with o_mem_req low -> no MD change.
REQ-044 I/O: i_in_port=5A, cmd C then cmd D -> A=5A, o_out_port=5A, o_out_valid high for one cycle.
REQ-045 Reset mid-read: assert i_rst in WAIT -> o_mem_req=0 at once, PC=00, SP=FF. Subsequent i_mem_ack leaves MD=00.
